data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface.
- Serves the CPU's data_address/data_read/data_write/data_writedata requests:
  - word RAM with combinational read and single-cycle byte-enabled write;
  - small memory-mapped status/counter block.
- Flags protocol violations (unmapped, misaligned, simultaneous read+write) with a sticky error and a captured address.
- Sits beside the harvard CPU top in the testbench and system wrapper; the instruction port is served separately.

---
 rtl/data_mem_responder_pkg.sv | 33 +++
 rtl/data_mem_responder_if.sv | 19 +
 rtl/data_mem_responder_ram.sv | 26 ++
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared memory-map constants and decode types for the CPU data-port responder.
package mem_map_pkg;

    localparam logic [3:0] OFS_CYCLE   = 4'h0;
    localparam logic [3:0] OFS_SCRATCH = 4'h4;
    localparam logic [3:0] OFS_WCOUNT  = 4'h8;
    localparam logic [3:0] OFS_STATUS  = 4'hC;

    localparam int STATUS_ERR_BIT = 0;

    typedef enum logic [1:0] {
        ACC_NONE    = 2'd0,
        ACC_RAM     = 2'd1,
        ACC_MMIO    = 2'd2,
        ACC_ILLEGAL = 2'd3
    } acc_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus: the CPU drives requests, the responder returns read data.
interface data_mem_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;

    modport master (
        output data_address, data_read, data_write, data_writedata, data_byteenable,
        input  data_readdata
    );

    modport slave (
        input  data_address, data_read, data_write, data_writedata, data_byteenable,
        output data_readdata
    );
endinterface

// File: rtl/data_mem_responder_ram.sv
// Word RAM with per-byte synchronous write and combinational read; contents are not reset.
module data_ram_bytewise
    import mem_map_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        be_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(2**ADDR_W)-1];

    // Byte-enabled write commit
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= be_merge(mem_q[addr_i], wdata_i, be_i);
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: address decode, word RAM, CYCLE/SCRATCH/WCOUNT/STATUS
// registers and sticky protocol-error capture.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    data_mem_if.slave   bus,
    output logic        err,
    output logic [31:0] err_addr
);

    acc_t        acc_s;
    logic        ram_hit_s;
    logic        mmio_hit_s;
    logic [3:0]  mmio_ofs_s;
    logic [31:0] ram_rdata_s;
    logic        ram_we_s;
    logic        mmio_wr_s;
    logic        status_clr_s;
    logic [31:0] rdata_s;

    logic [31:0] cycle_q,    cycle_d;
    logic [31:0] scratch_q,  scratch_d;
    logic [31:0] wcount_q,   wcount_d;
    logic        err_q,      err_d;
    logic [31:0] err_addr_q, err_addr_d;

    assign ram_hit_s  = (bus.data_address[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]);
    assign mmio_hit_s = (bus.data_address[31:4] == MMIO_BASE[31:4]);
    assign mmio_ofs_s = bus.data_address[3:0];

    // Classify the current request
    always_comb begin
        acc_s = ACC_NONE;
        if (!(bus.data_read || bus.data_write)) begin
            acc_s = ACC_NONE;
        end else if ((bus.data_read && bus.data_write) || (bus.data_address[1:0] != 2'b00)) begin
            acc_s = ACC_ILLEGAL;
        end else if (ram_hit_s) begin
            acc_s = ACC_RAM;
        end else if (mmio_hit_s) begin
            case (mmio_ofs_s)
                OFS_CYCLE, OFS_WCOUNT:   acc_s = bus.data_write ? ACC_ILLEGAL : ACC_MMIO;
                OFS_SCRATCH, OFS_STATUS: acc_s = ACC_MMIO;
                default:                 acc_s = ACC_ILLEGAL;
            endcase
        end else begin
            acc_s = ACC_ILLEGAL;
        end
    end

    // Reset gates the RAM write so an edge seen during reset is dropped
    assign ram_we_s  = reset && clk_enable && bus.data_write && (acc_s == ACC_RAM);
    assign mmio_wr_s = clk_enable && bus.data_write && (acc_s == ACC_MMIO);
    // Clear intent is decoded independently of legality for the clear+error collision
    assign status_clr_s = bus.data_write && mmio_hit_s && (mmio_ofs_s == OFS_STATUS)
                        && bus.data_byteenable[0] && bus.data_writedata[STATUS_ERR_BIT];

    data_ram_bytewise #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (bus.data_address[ADDR_W+1:2]),
        .wdata_i (bus.data_writedata),
        .be_i    (bus.data_byteenable),
        .rdata_o (ram_rdata_s)
    );

    // Zero-latency read mux
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (bus.data_read && (acc_s == ACC_RAM)) begin
            rdata_s = ram_rdata_s;
        end else if (bus.data_read && (acc_s == ACC_MMIO)) begin
            case (mmio_ofs_s)
                OFS_CYCLE:   rdata_s = cycle_q;
                OFS_SCRATCH: rdata_s = scratch_q;
                OFS_WCOUNT:  rdata_s = wcount_q;
                OFS_STATUS:  rdata_s = {31'd0, err_q};
                default:     rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.data_readdata = rdata_s;

    // Next-state for counters, scratch and error capture
    always_comb begin
        cycle_d    = clk_enable ? (cycle_q + 32'd1) : cycle_q;
        scratch_d  = scratch_q;
        wcount_d   = wcount_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (mmio_wr_s && (mmio_ofs_s == OFS_SCRATCH)) begin
            scratch_d = be_merge(scratch_q, bus.data_writedata, bus.data_byteenable);
        end else begin
            scratch_d = scratch_q;
        end

        if (ram_we_s && (bus.data_byteenable != 4'b0000) && (wcount_q != 32'hFFFF_FFFF)) begin
            wcount_d = wcount_q + 32'd1;
        end else begin
            wcount_d = wcount_q;
        end

        if (clk_enable && (acc_s == ACC_ILLEGAL)) begin
            err_d = 1'b1;
            if (!err_q || status_clr_s) begin
                err_addr_d = bus.data_address;
            end else begin
                err_addr_d = err_addr_q;
            end
        end else if (clk_enable && status_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q    <= 32'h0000_0000;
            scratch_q  <= 32'h0000_0000;
            wcount_q   <= 32'h0000_0000;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end else begin
            cycle_q    <= cycle_d;
            scratch_q  <= scratch_d;
            wcount_q   <= wcount_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: the driver queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_data_mem_responder;

    localparam logic [31:0] A_CYCLE   = 32'hFFFF_0000;
    localparam logic [31:0] A_SCRATCH = 32'hFFFF_0004;
    localparam logic [31:0] A_WCOUNT  = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        err;
    logic [31:0] err_addr;

    data_mem_if bus();

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus),
        .err        (err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    int          q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_val[$];
    string       q_name[$];

    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    bit          done   = 1'b0;
    logic [31:0] cyc_model = 32'd0;
    logic        prev_rn = 1'b0;
    logic        prev_ce = 1'b0;

    task automatic drive(input logic rn, input logic ce, input logic [31:0] a,
                         input logic rd, input logic wr, input logic [31:0] wd,
                         input logic [3:0] be);
        @(posedge clk);
        #1;
        if (prev_rn && prev_ce) cyc_model = cyc_model + 32'd1;
        reset               = rn;
        clk_enable          = ce;
        bus.data_address    = a;
        bus.data_read       = rd;
        bus.data_write      = wr;
        bus.data_writedata  = wd;
        bus.data_byteenable = be;
        if (!rn) cyc_model = 32'd0;
        prev_rn = rn;
        prev_ce = ce;
        cyc = cyc + 1;
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
        q_cyc.push_back(cyc);
        q_sel.push_back(sel);
        q_val.push_back(v);
        q_name.push_back(nm);
    endtask

    task automatic wr_t(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        drive(1'b1, 1'b1, a, 1'b0, 1'b1, wd, be);
    endtask

    task automatic rd_t(input logic [31:0] a, input logic [31:0] exp, input string nm);
        drive(1'b1, 1'b1, a, 1'b1, 1'b0, 32'd0, 4'b0000);
        expect_v(0, exp, nm);
    endtask

    task automatic rd_cyc(input string nm);
        drive(1'b1, 1'b1, A_CYCLE, 1'b1, 1'b0, 32'd0, 4'b0000);
        expect_v(0, cyc_model, nm);
    endtask

    task automatic idle_t();
        drive(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    endtask

    task automatic err_chk(input logic e, input logic [31:0] ea, input string nm);
        expect_v(1, {31'd0, e}, {nm, "_err"});
        expect_v(2, ea, {nm, "_eaddr"});
    endtask

    // Monitor: compares every expectation queued for the current cycle
    initial begin : monitor
        logic [31:0] act;
        int          guard;
        int          c;
        int          s;
        logic [31:0] v;
        string       nm;
        guard = 0;
        while (!done && guard < 5000) begin
            @(negedge clk);
            guard++;
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                c  = q_cyc.pop_front();
                s  = q_sel.pop_front();
                v  = q_val.pop_front();
                nm = q_name.pop_front();
                act = (s == 0) ? bus.data_readdata : ((s == 1) ? {31'd0, err} : err_addr);
                checks++;
                if (c != cyc) begin
                    errors++;
                    $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d", nm, c, cyc);
                end else if (act !== v) begin
                    errors++;
                    $display("FAIL %s: actual=%h required=%h", nm, act, v);
                end
            end
        end
        if (guard >= 5000) begin
            errors++;
            $display("FAIL timeout: driver did not finish within cycle budget");
        end
        while (q_cyc.size() > 0) begin
            nm = q_name.pop_front();
            void'(q_cyc.pop_front());
            void'(q_sel.pop_front());
            void'(q_val.pop_front());
            checks++;
            errors++;
            $display("FAIL %s: expectation never compared", nm);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Driver: directed stimulus
    initial begin
        reset               = 1'b0;
        clk_enable          = 1'b1;
        bus.data_address    = 32'd0;
        bus.data_read       = 1'b0;
        bus.data_write      = 1'b0;
        bus.data_writedata  = 32'd0;
        bus.data_byteenable = 4'b0000;

        // Reset state
        drive(1'b0, 1'b1, A_CYCLE, 1'b1, 1'b0, 32'd0, 4'b0000);
        expect_v(0, 32'd0, "rst_cycle");
        err_chk(1'b0, 32'd0, "rst");
        drive(1'b0, 1'b1, A_SCRATCH, 1'b1, 1'b0, 32'd0, 4'b0000);
        expect_v(0, 32'd0, "rst_scratch");
        drive(1'b0, 1'b1, A_WCOUNT, 1'b1, 1'b0, 32'd0, 4'b0000);
        expect_v(0, 32'd0, "rst_wcount");
        rd_cyc("cycle_after_release");
        rd_cyc("cycle_counting");

        // Byte-enabled RAM writes and read-after-write
        wr_t(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        wr_t(32'h0000_0010, 32'h0000_0011, 4'b0001);
        rd_t(32'h0000_0010, 32'hDEAD_BE11, "raw_0x10");
        rd_t(A_WCOUNT, 32'd2, "wcount_2");
        wr_t(32'h0000_0000, 32'h0102_0304, 4'b1111);
        wr_t(32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111);
        rd_t(32'h0000_0FFC, 32'hCAFE_F00D, "ram_top_word");
        wr_t(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
        rd_t(32'h0000_0010, 32'hDEAD_BE11, "be_zero_no_change");
        wr_t(32'h0000_0014, 32'h0000_0000, 4'b1111);
        wr_t(32'h0000_0014, 32'hAABB_CCDD, 4'b1010);
        rd_t(32'h0000_0014, 32'hAA00_CC00, "be_1010");
        rd_t(A_WCOUNT, 32'd6, "wcount_6");
        wr_t(A_SCRATCH, 32'h1234_5678, 4'b1111);
        wr_t(A_SCRATCH, 32'h0000_AB00, 4'b0010);
        rd_t(A_SCRATCH, 32'h1234_AB78, "scratch_be");
        err_chk(1'b0, 32'd0, "no_err_yet");
        rd_t(A_WCOUNT, 32'd6, "wcount_ignores_mmio");

        // Misaligned read, then unmapped write while err is set
        rd_t(32'h0000_0012, 32'd0, "misaligned_rd");
        idle_t();
        err_chk(1'b1, 32'h0000_0012, "misaligned");
        wr_t(32'h8000_0000, 32'hFFFF_FFFF, 4'b1111);
        rd_t(32'h0000_0000, 32'h0102_0304, "unmapped_no_alias");
        err_chk(1'b1, 32'h0000_0012, "err_addr_held");
        rd_t(A_WCOUNT, 32'd6, "wcount_after_unmapped");

        // STATUS write-1-to-clear
        wr_t(A_STATUS, 32'h0000_0001, 4'b0010);
        rd_t(A_STATUS, 32'd1, "status_no_clr_be");
        wr_t(A_STATUS, 32'hFFFF_FFFE, 4'b1111);
        rd_t(A_STATUS, 32'd1, "status_no_clr_bit");
        wr_t(A_STATUS, 32'h0000_0001, 4'b0001);
        rd_t(A_STATUS, 32'd0, "status_cleared");
        err_chk(1'b0, 32'h0000_0012, "cleared");
        drive(1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0099, 4'b1111);
        expect_v(0, 32'd0, "rdwr_readdata");
        idle_t();
        err_chk(1'b1, 32'h0000_0000, "rdwr");
        rd_t(32'h0000_0000, 32'h0102_0304, "rdwr_no_write");
        drive(1'b1, 1'b1, A_STATUS, 1'b1, 1'b1, 32'h0000_0001, 4'b0001);
        idle_t();
        err_chk(1'b1, A_STATUS, "clr_and_illegal");
        wr_t(A_STATUS, 32'h0000_0001, 4'b0001);
        wr_t(A_WCOUNT, 32'h0000_0005, 4'b1111);
        rd_t(A_WCOUNT, 32'd6, "ro_write_ignored");
        err_chk(1'b1, A_WCOUNT, "ro_write");
        wr_t(A_STATUS, 32'h0000_0001, 4'b0001);
        rd_t(32'hFFFF_0010, 32'd0, "beyond_mmio_rd");
        idle_t();
        err_chk(1'b1, 32'hFFFF_0010, "beyond_mmio");
        wr_t(A_STATUS, 32'h0000_0001, 4'b0001);

        // clk_enable low freezes everything
        rd_cyc("cycle_before_hold");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 32'h5555_5555, 4'b1111);
        end
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 32'd0, 4'b0000);
        rd_cyc("cycle_after_hold");
        err_chk(1'b0, 32'hFFFF_0010, "hold_no_err");
        rd_cyc("cycle_resumes");
        rd_t(32'h0000_0010, 32'hDEAD_BE11, "hold_ram_unchanged");
        rd_t(A_WCOUNT, 32'd6, "hold_wcount_unchanged");

        // CYCLE wrap and WCOUNT saturation
        idle_t();
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        cyc_model = 32'hFFFF_FFFE;
        rd_t(A_CYCLE, 32'hFFFF_FFFF, "cycle_ffffffff");
        rd_t(A_CYCLE, 32'h0000_0000, "cycle_wrap_0");
        rd_t(A_CYCLE, 32'h0000_0001, "cycle_wrap_1");
        idle_t();
        force dut.wcount_q = 32'hFFFF_FFFF;
        #1;
        release dut.wcount_q;
        rd_t(A_WCOUNT, 32'hFFFF_FFFF, "wcount_forced");
        wr_t(32'h0000_0018, 32'h0000_0001, 4'b1111);
        rd_t(A_WCOUNT, 32'hFFFF_FFFF, "wcount_saturated");
        rd_t(32'h0000_0018, 32'h0000_0001, "sat_write_landed");

        // Asynchronous reset mid-cycle
        wr_t(A_SCRATCH, 32'hA5A5_A5A5, 4'b1111);
        rd_t(A_SCRATCH, 32'hA5A5_A5A5, "scratch_a5");
        rd_t(32'h0000_0013, 32'd0, "pre_reset_misaligned");
        idle_t();
        err_chk(1'b1, 32'h0000_0013, "pre_reset");
        drive(1'b0, 1'b1, A_SCRATCH, 1'b1, 1'b0, 32'd0, 4'b0000);
        expect_v(0, 32'd0, "async_rst_scratch");
        err_chk(1'b0, 32'd0, "async_rst");
        drive(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h7777_7777, 4'b1111);
        rd_t(32'h0000_0010, 32'hDEAD_BE11, "write_dropped_in_reset");
        rd_t(A_WCOUNT, 32'd0, "wcount_after_reset");
        rd_cyc("cycle_after_reset");

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
